// File: rtl/gavgunpool.sv
// Global-average unpooling: expands each accepted sample into POOL_SIZE output beats,
// each beat being the sample scaled by 1/POOL_SIZE (SCALE=1) or passed through (SCALE=0).
module gavgunpool #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned POOL_SIZE  = 256,
    parameter int unsigned SCALE      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          gavgunpool_ready_in,
    input  logic                          gavgunpool_valid_in,
    input  logic [DATA_WIDTH-1:0]         gavgunpool_data_in,
    input  logic                          gavgunpool_ready_out,
    output logic                          gavgunpool_valid_out,
    output logic [DATA_WIDTH-1:0]         gavgunpool_data_out,
    output logic                          gavgunpool_last_out,
    output logic [$clog2(POOL_SIZE)-1:0]  gavgunpool_index_out
);

    localparam int unsigned IDX_W = $clog2(POOL_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POOL_SIZE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_scaled;
    logic [IDX_W-1:0]      r_index;
    logic [IDX_W-1:0]      w_index_nxt;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_out_hs;
    logic                  w_in_hs;
    logic                  w_ready_in;

    // Scaling is a pure shift because POOL_SIZE is a power of two; truncates toward zero.
    generate
        if (SCALE != 0) begin : g_scale
            assign w_scaled = gavgunpool_data_in >> IDX_W;
        end else begin : g_pass
            assign w_scaled = gavgunpool_data_in;
        end
    endgenerate

    assign w_valid    = (r_state == S_EMIT);
    assign w_last     = w_valid && (r_index == LAST_IDX);
    assign w_out_hs   = w_valid && gavgunpool_ready_out;
    // Accepting on the final-beat handshake keeps back-to-back samples bubble-free.
    assign w_ready_in = !rst && (!w_valid || (w_out_hs && w_last));
    assign w_in_hs    = gavgunpool_valid_in && w_ready_in;

    assign gavgunpool_ready_in  = w_ready_in;
    assign gavgunpool_valid_out = w_valid;
    assign gavgunpool_data_out  = r_data;
    assign gavgunpool_last_out  = w_last;
    assign gavgunpool_index_out = r_index;

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        case (r_state)
            S_IDLE: begin
                if (w_in_hs) begin
                    w_data_nxt  = w_scaled;
                    w_index_nxt = '0;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_out_hs) begin
                    if (!w_last) begin
                        w_index_nxt = IDX_W'(r_index + IDX_W'(1));
                    end else if (w_in_hs) begin
                        w_data_nxt  = w_scaled;
                        w_index_nxt = '0;
                    end else begin
                        w_index_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
        end
    end

endmodule

// File: tb/tb_gavgunpool.sv
// Bench for gavgunpool: three configurations driven together and checked against a
// queue-of-expected-beats model built from the unpooling rules.
module tb_gavgunpool;

    localparam int N = 3;
    localparam int unsigned P_A = 4;
    localparam int unsigned P_B = 4;
    localparam int unsigned P_C = 2;

    typedef struct {
        logic [11:0] d;
        int          idx;
        bit          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin  [N];
    logic [11:0] din  [N];
    logic        rout [N];
    logic        rin  [N];
    logic        vout [N];
    logic [11:0] dout [N];
    logic        lout [N];
    logic [7:0]  iout [N];
    logic [1:0]  idx_a;
    logic [1:0]  idx_b;
    logic [0:0]  idx_c;

    int    pool  [N] = '{4, 4, 2};
    int    shamt [N] = '{2, 2, 1};
    int    scl   [N] = '{1, 0, 1};
    beat_t q     [N][$];
    int    acc   [N];
    int    passed = 0;
    int    total  = 0;
    bit    chk_en = 1'b0;

    always #5 clk = ~clk;

    assign iout[0] = 8'(idx_a);
    assign iout[1] = 8'(idx_b);
    assign iout[2] = 8'(idx_c);

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(P_A), .SCALE(1)) u_a (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rin[0]), .gavgunpool_valid_in(vin[0]), .gavgunpool_data_in(din[0]),
        .gavgunpool_ready_out(rout[0]), .gavgunpool_valid_out(vout[0]), .gavgunpool_data_out(dout[0]),
        .gavgunpool_last_out(lout[0]), .gavgunpool_index_out(idx_a)
    );

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(P_B), .SCALE(0)) u_b (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rin[1]), .gavgunpool_valid_in(vin[1]), .gavgunpool_data_in(din[1]),
        .gavgunpool_ready_out(rout[1]), .gavgunpool_valid_out(vout[1]), .gavgunpool_data_out(dout[1]),
        .gavgunpool_last_out(lout[1]), .gavgunpool_index_out(idx_b)
    );

    gavgunpool #(.DATA_WIDTH(12), .POOL_SIZE(P_C), .SCALE(1)) u_c (
        .clk(clk), .rst(rst),
        .gavgunpool_ready_in(rin[2]), .gavgunpool_valid_in(vin[2]), .gavgunpool_data_in(din[2]),
        .gavgunpool_ready_out(rout[2]), .gavgunpool_valid_out(vout[2]), .gavgunpool_data_out(dout[2]),
        .gavgunpool_last_out(lout[2]), .gavgunpool_index_out(idx_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        total++;
        $error("FAIL timeout %s", tag);
    endtask

    // One clock: compare outputs with the model, then advance the model by this cycle's handshakes.
    task automatic tick();
        bit    ev  [N];
        bit    erdy[N];
        beat_t b;
        #1;
        for (int i = 0; i < N; i++) begin
            ev[i]   = (q[i].size() != 0);
            erdy[i] = !rst && (q[i].size() == 0 || (q[i].size() == 1 && rout[i] === 1'b1));
            if (chk_en) begin
                chk($sformatf("valid_out[%0d]", i), 32'(vout[i]), 32'(ev[i]));
                chk($sformatf("ready_in[%0d]", i), 32'(rin[i]), 32'(erdy[i]));
                if (ev[i]) begin
                    chk($sformatf("data_out[%0d]", i), 32'(dout[i]), 32'(q[i][0].d));
                    chk($sformatf("index_out[%0d]", i), 32'(iout[i]), 32'(q[i][0].idx));
                    chk($sformatf("last_out[%0d]", i), 32'(lout[i]), 32'(q[i][0].last));
                end else begin
                    chk($sformatf("last_idle[%0d]", i), 32'(lout[i]), 32'd0);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                q[i].delete();
            end else begin
                if (ev[i] && rout[i] === 1'b1) void'(q[i].pop_front());
                if (vin[i] === 1'b1 && erdy[i]) begin
                    for (int k = 0; k < pool[i]; k++) begin
                        b.d    = (scl[i] != 0) ? 12'(din[i] / (12'd1 << shamt[i])) : din[i];
                        b.idx  = k;
                        b.last = (k == pool[i] - 1);
                        q[i].push_back(b);
                    end
                    acc[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [11:0] v);
        int n;
        n      = acc[i];
        vin[i] = 1'b1;
        din[i] = v;
        for (int c = 0; c < 600 && acc[i] == n; c++) tick();
        if (acc[i] == n) timeout($sformatf("send[%0d]", i));
        vin[i] = 1'b0;
    endtask

    task automatic drain_all();
        for (int c = 0; c < 1200 && (q[0].size() + q[1].size() + q[2].size()) != 0; c++) tick();
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) timeout("drain");
        tick();
    endtask

    initial begin
        int    n;
        logic  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vin[i]  = 1'b0;
            din[i]  = '0;
            rout[i] = 1'b1;
            acc[i]  = 0;
        end
        @(posedge clk);
        #1;
        tick();
        tick();
        chk_en = 1'b1;
        rst    = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_valid[%0d]", i), 32'(vout[i]), 32'd0);
            chk($sformatf("rst_data[%0d]", i), 32'(dout[i]), 32'd0);
            chk($sformatf("rst_index[%0d]", i), 32'(iout[i]), 32'd0);
            chk($sformatf("rst_last[%0d]", i), 32'(lout[i]), 32'd0);
        end

        // Single samples with scaling, including truncation and full-scale.
        send(0, 12'h100);
        drain_all();
        send(0, 12'h007);
        drain_all();
        send(0, 12'hFFF);
        drain_all();

        // Back-to-back samples with valid_in held high, pass-through config.
        n      = acc[1];
        vin[1] = 1'b1;
        din[1] = 12'hABC;
        for (int c = 0; c < 40 && acc[1] < n + 2; c++) begin
            tick();
            if (acc[1] == n + 1) din[1] = 12'h123;
        end
        if (acc[1] != n + 2) timeout("back_to_back");
        vin[1] = 1'b0;
        drain_all();

        // Backpressure pattern on the output side.
        send(0, 12'h100);
        for (int k = 0; k < 7; k++) begin
            rout[0] = pat[k];
            tick();
        end
        rout[0] = 1'b1;
        drain_all();

        // Reset after beat index 1 abandons the rest of the expansion.
        send(0, 12'h100);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(vout[0]), 32'd0);
        chk("midrst_data", 32'(dout[0]), 32'd0);
        chk("midrst_index", 32'(iout[0]), 32'd0);
        chk("midrst_last", 32'(lout[0]), 32'd0);
        send(0, 12'h080);
        drain_all();

        // Smallest pool: second sample held valid must wait for the final beat.
        n      = acc[2];
        vin[2] = 1'b1;
        din[2] = 12'h001;
        for (int c = 0; c < 20 && acc[2] < n + 2; c++) begin
            tick();
            if (acc[2] == n + 1) din[2] = 12'h002;
        end
        if (acc[2] != n + 2) timeout("pool2");
        vin[2] = 1'b0;
        drain_all();

        // Randomized traffic on all configurations with occasional resets.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                vin[i]  = 1'($urandom % 2);
                din[i]  = 12'($urandom);
                rout[i] = ($urandom % 4) != 0;
            end
            rst = ($urandom % 97) == 0;
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            vin[i]  = 1'b0;
            rout[i] = 1'b1;
        end
        drain_all();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gavgunpool.md
Name: gavgunpool

Overview:
- Inverse-direction companion to global average pooling: accepts one sample per handshake and expands it into a stream of POOL_SIZE output beats.
- Each beat is either the sample divided by POOL_SIZE (SCALE=1, average-pool gradient distribution) or the unmodified sample (SCALE=0, plain broadcast/upsample).
- Sits after a reduced-dimension stage in the 1D CNN datapath, using the same valid/ready streaming interface as the pooling blocks.

Parameters:
- DATA_WIDTH, 12, width of input and output data, unsigned.
- POOL_SIZE, 256, number of output beats per input sample; must be a power of two and >= 2.
- SCALE, 1, 1 = each output beat is the input logically shifted right by clog2(POOL_SIZE); 0 = input passed through unchanged.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- gavgunpool_ready_in  output  1  block can accept an input sample this cycle.
- gavgunpool_valid_in  input  1  input sample valid.
- gavgunpool_data_in  input  DATA_WIDTH  input sample.
- gavgunpool_ready_out  input  1  downstream accepts the current output beat.
- gavgunpool_valid_out  output  1  output beat valid.
- gavgunpool_data_out  output  DATA_WIDTH  output beat data.
- gavgunpool_last_out  output  1  marks the final beat (index POOL_SIZE-1) of an expansion.
- gavgunpool_index_out  output  clog2(POOL_SIZE)  index of the current beat within the expansion, 0..POOL_SIZE-1.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset (rst high at a clock edge) clears valid_out, data_out, last_out and index_out to 0. ready_in is forced to 0 while rst is high.
- Reset mid-expansion abandons the remaining beats; nothing is emitted for that sample after reset.
- Input acceptance occurs when valid_in && ready_in.
- ready_in is combinational and equals ~valid_out | (valid_out & ready_out & last_out). This allows a new sample to be accepted in the same cycle the final beat is consumed, so back-to-back samples run with no bubble.
- Two-state FSM:
  - IDLE (valid_out=0): ready_in=1. On accept, register data and go to EMIT with index=0 and valid_out=1 on the next cycle. Latency from input handshake to first valid beat is 1 cycle.
  - EMIT (valid_out=1), on each output handshake (valid_out && ready_out):
    - If index < POOL_SIZE-1: index increments and data is held.
    - If index == POOL_SIZE-1 and an input is accepted in the same cycle: load the new sample, set index=0, stay in EMIT.
    - If index == POOL_SIZE-1 and no input is accepted: valid_out=0, index=0, return to IDLE.
- Data rules:
  - data_out = SCALE ? (data_in >> clog2(POOL_SIZE)) : data_in.
  - The value is computed once at accept and registered. Truncation toward zero; no rounding.
- last_out = valid_out && (index == POOL_SIZE-1). It is a registered-state decode, so it may be combinational from index.
- Backpressure: while valid_out && !ready_out, data_out, index_out and last_out must hold stable. valid_out is never deasserted without a handshake.
- Throughput: one output beat per cycle under no backpressure. Exactly POOL_SIZE beats per accepted input; never more, never fewer.
- Input stream is unconstrained: valid_in may be held high indefinitely. Samples are accepted only via ready_in; no sample is dropped or duplicated.

Test Plan:
- DATA_WIDTH=12, POOL_SIZE=4, SCALE=1; single input 0x100, ready_out held 1 -> beats 0x040 x4 on consecutive cycles starting 1 cycle after accept; index 0,1,2,3; last_out only on index 3; valid_out low afterwards; ready_in high again.
- Same config; input 0x007 -> four beats of 0x001 (truncation). Input 0xFFF -> four beats of 0x3FF.
- SCALE=0, POOL_SIZE=4; inputs 0xABC then 0x123 with valid_in held high -> 8 consecutive beats (0xABC x4, 0x123 x4) with no idle cycle; ready_in pulses high only on the cycle of the 4th beat handshake.
- Backpressure: input 0x100, ready_out toggled 1,0,0,1,0,1,1 -> exactly four 0x040 beats; data/index/last stable during stall cycles; ready_in stays low until the last beat is taken.
- Reset mid-operation: assert rst for 1 cycle after beat index 1 -> next cycle valid_out=0, index_out=0, data_out=0; no further beats of the old sample; a following input 0x080 yields four beats of 0x020 starting at index 0.
- Boundary: POOL_SIZE=2, SCALE=1; input 0x001 -> two beats of 0x000 with last on the second; an input presented during the first beat is not accepted until the second beat's handshake.
